event_detector_multi: RTL

EVENT_DETECTOR_MULTI -- requirements
Module: event_detector_multi

---
 rtl/event_detector_multi.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/event_detector_multi.sv
// event_detector_multi
// Multi-channel edge detector with per-channel sticky pending flags, an
// interrupt summary and a saturating aggregate event counter.
//
// Each channel compares its sampled level against last cycle's level and
// reports rising, falling or both edges according to a global mode. Events
// are suppressed for a short arming window after reset release, so levels
// that are already high when reset releases are not reported as edges.
//
// Optional feature macro: EVENT_DETECTOR_MULTI_SYNC_EN
//   Undefined : inputs are used directly; latency 1 edge; arming window 1 edge.
//   Defined   : two-flop synchronizer per channel; latency 3 edges; arming 3 edges.

module event_detector_multi #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  i_Data,
    input  logic [1:0]       i_Mode,
    input  logic [N_CH-1:0]  i_Mask,
    input  logic [N_CH-1:0]  i_Clear,
    input  logic             i_Cnt_Clr,
    output logic [N_CH-1:0]  o_Event,
    output logic [N_CH-1:0]  o_Pending,
    output logic             o_Irq,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Cnt_Sat
);

    // Popcount width holds 0..N_CH; the sum is wide enough that adding a full
    // popcount to an all-ones count can never wrap before the saturation test.
    localparam int PC_W  = $clog2(N_CH + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [SUM_W-1:0] SUM_MAX = {{PC_W{1'b0}}, CNT_MAX};

    // Number of set bits in an event vector.
    function automatic logic [PC_W-1:0] popcount(input logic [N_CH-1:0] vec);
        logic [PC_W-1:0] acc;
        acc = {PC_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            acc = acc + PC_W'(vec[i]);
        end
        return acc;
    endfunction

    logic [N_CH-1:0]  data_s;
    logic [N_CH-1:0]  prev_r;
    logic [1:0]       arm_cnt_r;
    logic             armed_s;
    logic [N_CH-1:0]  rise_s;
    logic [N_CH-1:0]  fall_s;
    logic [N_CH-1:0]  raw_s;
    logic [N_CH-1:0]  ev_s;
    logic [N_CH-1:0]  pend_nxt_s;
    logic [PC_W-1:0]  pop_s;
    logic [SUM_W-1:0] base_s;
    logic [SUM_W-1:0] sum_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             sat_nxt_s;

`ifdef EVENT_DETECTOR_MULTI_SYNC_EN
    localparam logic [1:0] ARM_CNT = 2'd3;

    logic [N_CH-1:0] sync1_r;
    logic [N_CH-1:0] sync2_r;

    // Two-flop synchronizer bringing the asynchronous levels into clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= {N_CH{1'b0}};
            sync2_r <= {N_CH{1'b0}};
        end else begin
            sync1_r <= i_Data;
            sync2_r <= sync1_r;
        end
    end

    assign data_s = sync2_r;
`else
    localparam logic [1:0] ARM_CNT = 2'd1;

    assign data_s = i_Data;
`endif

    // Arming counter: counts post-release edges up to ARM_CNT and then holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_r <= 2'd0;
        end else if (arm_cnt_r != ARM_CNT) begin
            arm_cnt_r <= arm_cnt_r + 2'd1;
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    assign armed_s = (arm_cnt_r == ARM_CNT);

    // Edge detection, masking, pending update and saturating count arithmetic.
    always_comb begin
        rise_s = data_s & ~prev_r;
        fall_s = ~data_s & prev_r;
        case (i_Mode)
            2'b01:   raw_s = rise_s;
            2'b10:   raw_s = fall_s;
            2'b11:   raw_s = rise_s | fall_s;
            default: raw_s = {N_CH{1'b0}};
        endcase

        if (armed_s) begin
            ev_s = raw_s & ~i_Mask;
        end else begin
            ev_s = {N_CH{1'b0}};
        end

        // A new event wins over a simultaneous clear so it is never lost.
        pend_nxt_s = (o_Pending & ~i_Clear) | ev_s;

        pop_s = popcount(ev_s);
        if (i_Cnt_Clr) begin
            base_s = {SUM_W{1'b0}};
        end else begin
            base_s = {{PC_W{1'b0}}, o_Count};
        end
        sum_s = base_s + {{CNT_W{1'b0}}, pop_s};

        if (sum_s >= SUM_MAX) begin
            cnt_nxt_s = CNT_MAX;
            sat_nxt_s = 1'b1;
        end else begin
            cnt_nxt_s = sum_s[CNT_W-1:0];
            sat_nxt_s = i_Cnt_Clr ? 1'b0 : o_Cnt_Sat;
        end
    end

    // History, event pulses, pending flags, interrupt and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r    <= {N_CH{1'b0}};
            o_Event   <= {N_CH{1'b0}};
            o_Pending <= {N_CH{1'b0}};
            o_Irq     <= 1'b0;
            o_Count   <= {CNT_W{1'b0}};
            o_Cnt_Sat <= 1'b0;
        end else begin
            prev_r    <= data_s;
            o_Event   <= ev_s;
            o_Pending <= pend_nxt_s;
            o_Irq     <= |pend_nxt_s;
            o_Count   <= cnt_nxt_s;
            o_Cnt_Sat <= sat_nxt_s;
        end
    end

endmodule
